// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Optional feature macro: MIPS_ADDI_EN (adds the addi execute/writeback states).
package mips_ctrl_pkg;

   // State encodings are exposed on state_o, so the values are fixed.
   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXECUTE   = 4'd6,
      ST_ALU_WB    = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_ADDI_EX   = 4'd10,
      ST_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] SRCB_REG     = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Ungated control word; the top applies handshake and timeout gating.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // States that wait on the memory ready handshake.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure state-to-control-word decoder for the multicycle MIPS control FSM.
// Fetch strobes are emitted ungated here; the top gates them with mem_ready.
// Optional feature macro: MIPS_ADDI_EN (decodes the addi states).
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   // Decode the registered state into the datapath control word.
   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         ST_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         ST_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
`ifdef MIPS_ADDI_EN
         ST_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS datapath, with memory
// stall counting, optional access timeout and illegal-opcode flagging.
// Optional feature macro: MIPS_ADDI_EN (makes opcode 0x08 legal).
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state_o
);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
   logic               mem_err_reg, mem_err_next;
   logic               in_mem_state;
   logic               timeout;
   logic               mem_done;
   ctrl_t              ctrl;

   // A timeout cycle abandons the access: the handshake is ignored and strobes drop.
   assign in_mem_state = is_mem_state(state_reg);
   assign timeout      = (MEM_TIMEOUT != 0) && in_mem_state &&
                         (stall_cnt_reg == CNT_W'(MEM_TIMEOUT));
   assign mem_done     = mem_ready && !timeout;

   // State, stall counter and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_FETCH;
         stall_cnt_reg <= '0;
         mem_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         mem_err_reg   <= mem_err_next;
      end
   end

   // Next-state, illegal opcode pulse, stall counter and error update.
   always_comb begin
      state_next     = state_reg;
      illegal_op     = 1'b0;
      stall_cnt_next = '0;
      mem_err_next   = mem_err_reg | timeout;
      if (in_mem_state && !mem_ready && !timeout)
         stall_cnt_next = stall_cnt_reg + 1'b1;
      case (state_reg)
         ST_FETCH:     if (mem_done) state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = ST_MEM_ADDR;
               OP_RTYPE:     state_next = ST_EXECUTE;
               OP_BEQ:       state_next = ST_BRANCH;
               OP_J:         state_next = ST_JUMP;
`ifdef MIPS_ADDI_EN
               OP_ADDI:      state_next = ST_ADDI_EX;
`endif
               default: begin
                  state_next = ST_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         ST_MEM_ADDR:  state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  if (mem_done) state_next = ST_MEM_WB;
         ST_MEM_WB:    state_next = ST_FETCH;
         ST_MEM_WRITE: if (mem_done) state_next = ST_FETCH;
         ST_EXECUTE:   state_next = ST_ALU_WB;
         ST_ALU_WB:    state_next = ST_FETCH;
         ST_BRANCH:    state_next = ST_FETCH;
         ST_JUMP:      state_next = ST_FETCH;
`ifdef MIPS_ADDI_EN
         ST_ADDI_EX:   state_next = ST_ADDI_WB;
         ST_ADDI_WB:   state_next = ST_FETCH;
`endif
         default:      state_next = ST_FETCH;
      endcase
      if (timeout)
         state_next = ST_FETCH;
   end

   mips_ctrl_outdec u_outdec (
      .state (state_reg),
      .ctrl  (ctrl)
   );

   // Fetch only loads IR/PC on a completed access; all strobes drop on timeout.
   assign pc_write      = ctrl.pc_write & ((state_reg != ST_FETCH) | mem_done) & !timeout;
   assign ir_write      = ctrl.ir_write & mem_done;
   assign mem_read      = ctrl.mem_read & !timeout;
   assign mem_write     = ctrl.mem_write & !timeout;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign mem_err       = mem_err_reg;
   assign state_o       = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases plus random
// instruction streams checked against an instruction-level path model.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op, mem_err;
   logic [3:0] state_o;
   logic [15:0] obs_ctrl;

   int n_pass  = 0;
   int n_total = 0;
   logic err_exp = 1'b0;

   logic [5:0] op_tab [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .illegal_op    (illegal_op),
      .mem_err       (mem_err),
      .state_o       (state_o)
   );

   assign obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         6'h00, 6'h23, 6'h2B, 6'h04, 6'h02: return 1'b1;
`ifdef MIPS_ADDI_EN
         6'h08: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // Expected control word for a state, from the per-state output table.
   function automatic logic [15:0] exp_ctrl(input int st, input logic mr, input logic to);
      logic pcw = 0, pcc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rdst = 0, rw = 0, sa = 0;
      logic [1:0] sb = 0, aop = 0, ps = 0;
      case (st)
         0: begin mrd = !to; irw = mr && !to; pcw = mr && !to; sb = 2'd1; end
         1: sb = 2'd3;
         2: begin sa = 1; sb = 2'd2; end
         3: begin mrd = !to; iod = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mwr = !to; iod = 1; end
         6: begin sa = 1; aop = 2'd2; end
         7: begin rw = 1; rdst = 1; end
         8: begin sa = 1; aop = 2'd1; pcc = 1; ps = 2'd1; end
         9: begin pcw = 1; ps = 2'd2; end
         10: begin sa = 1; sb = 2'd2; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, ps};
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h required %0h", tag, obs, expv);
   endtask

   // One clock of the model: drive mem_ready, then check the DUT mid-cycle.
   task automatic step(input int st, input logic mr, input logic to, input logic ill);
      mem_ready = mr;
      @(negedge clk);
      chk("state", 32'(state_o), 32'(st));
      chk("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(st, mr, to)));
      chk("illegal_op", 32'(illegal_op), 32'(ill));
      chk("mem_err", 32'(mem_err), 32'(err_exp));
      @(posedge clk);
      #1;
   endtask

   // Walk one instruction from FETCH with the given wait counts.
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      logic legal;
      legal  = op_legal(op);
      opcode = op;
      $display("instr op=%02h fetch_waits=%0d mem_waits=%0d legal=%0d", op, wf, wm, legal);
      repeat (wf) step(0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0);
      step(1, rnd_bit(), 1'b0, !legal);
      case (op)
         6'h23: begin
            step(2, rnd_bit(), 1'b0, 1'b0);
            repeat (wm) step(3, 1'b0, 1'b0, 1'b0);
            step(3, 1'b1, 1'b0, 1'b0);
            step(4, rnd_bit(), 1'b0, 1'b0);
         end
         6'h2B: begin
            step(2, rnd_bit(), 1'b0, 1'b0);
            repeat (wm) step(5, 1'b0, 1'b0, 1'b0);
            step(5, 1'b1, 1'b0, 1'b0);
         end
         6'h00: begin step(6, rnd_bit(), 1'b0, 1'b0); step(7, rnd_bit(), 1'b0, 1'b0); end
         6'h04: step(8, rnd_bit(), 1'b0, 1'b0);
         6'h02: step(9, rnd_bit(), 1'b0, 1'b0);
         6'h08: if (legal) begin
            step(10, rnd_bit(), 1'b0, 1'b0);
            step(11, rnd_bit(), 1'b0, 1'b0);
         end
         default: ;
      endcase
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      err_exp = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] op;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 6'h00;
      #2;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0)));
      chk("reset_illegal", 32'(illegal_op), 32'd0);
      chk("reset_mem_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed: R-type, lw with 3 waits in MEM_READ, sw, beq, j, illegal, addi.
      run_instr(6'h00, 0, 0);
      run_instr(6'h23, 0, 3);
      run_instr(6'h2B, 1, 2);
      run_instr(6'h04, 0, 0);
      run_instr(6'h02, 2, 0);
      run_instr(6'h3F, 0, 0);
      run_instr(6'h08, 0, 0);

      // Random instruction stream, stalls kept below the timeout.
      for (int i = 0; i < 60; i++) begin
         int r;
         r = int'($urandom_range(0, 7));
         if (r == 7) op = 6'($urandom);
         else op = op_tab[r];
         run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset mid-MEM_READ: immediate return to FETCH, no writeback.
      opcode = 6'h23;
      $display("instr op=23 reset asserted mid MEM_READ");
      step(0, 1'b1, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0, 1'b0);
      step(2, 1'b0, 1'b0, 1'b0);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_state", 32'(state_o), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(state_o), 32'd0);
      chk("midrst_reg_write", 32'(reg_write), 32'd0);
      chk("midrst_mem_err", 32'(mem_err), 32'd0);
      chk("midrst_fetch", 32'({mem_read, i_or_d}), 32'b10);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_instr(6'h00, 0, 0);

      // Timeout in FETCH: four waits, abandon cycle with strobes low, then retry.
      $display("instr fetch timeout");
      repeat (4) step(0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      err_exp = 1'b1;
      step(0, 1'b0, 1'b0, 1'b0);
      // Timeout in MEM_WRITE, mem_err stays set.
      $display("instr sw write timeout");
      opcode = 6'h2B;
      step(0, 1'b1, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0, 1'b0);
      step(2, 1'b0, 1'b0, 1'b0);
      repeat (4) step(5, 1'b0, 1'b0, 1'b0);
      step(5, 1'b1, 1'b1, 1'b0);
      run_instr(6'h00, 0, 0);
      run_instr(6'h23, 3, 3);
      pulse_reset();
      run_instr(6'h02, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback. It drives every datapath select, including reg_dst, the select on the 5-bit write-register mux (1 = rd, 0 = rt). It stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 0, max stall cycles per memory access before mem_err (0 = wait forever)
CNT_W, 8, width of stall counter; MEM_TIMEOUT must be < 2**CNT_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from IR, sampled in DECODE
mem_ready  input  1  memory completed current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  memory address select, 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe, held until mem_ready
mem_write  output  1  memory write strobe, held until mem_ready
ir_write  output  1  IR load
mem_to_reg  output  1  writeback data select, 1 = MDR, 0 = ALUOut
reg_dst  output  1  write-register mux select, 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
alu_op  output  2  0 = add, 1 = sub, 2 = funct-decoded
pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
illegal_op  output  1  one-cycle pulse: unknown opcode in DECODE
mem_err  output  1  sticky; set on memory timeout, cleared only by reset
state_o  output  4  current state encoding, debug

Behaviour:
- Reset (async, rst_n low):
  - State goes to FETCH, stall counter to 0, mem_err to 0.
  - Outputs are decoded from state, so while reset is held they show FETCH values.
  - illegal_op is 0 during reset.
- All outputs are combinational from the registered state (Moore). The only exceptions are the ir_write and pc_write gating below, which also depend on mem_ready.
- States and encodings:
  - FETCH (0):
    - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
    - ir_write and pc_write equal mem_ready.
    - Moves to DECODE on mem_ready; otherwise stays.
  - DECODE (1):
    - Drives alu_src_a=0, alu_src_b=3, alu_op=0.
    - Next state by opcode: 0x23 or 0x2B -> MEM_ADDR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x02 -> JUMP.
    - Any other opcode -> FETCH with illegal_op=1 for this cycle.
  - MEM_ADDR (2): drives alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEM_READ if opcode=0x23, else MEM_WRITE.
  - MEM_READ (3): drives mem_read=1, i_or_d=1. Goes to MEM_WB on mem_ready.
  - MEM_WB (4): drives reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEM_WRITE (5): drives mem_write=1, i_or_d=1. Goes to FETCH on mem_ready.
  - EXECUTE (6): drives alu_src_a=1, alu_src_b=0, alu_op=2. Goes to ALU_WB.
  - ALU_WB (7): drives reg_write=1, mem_to_reg=0, reg_dst=1. Goes to FETCH.
  - BRANCH (8): drives alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Goes to FETCH.
  - JUMP (9): drives pc_write=1, pc_source=2. Goes to FETCH.
- Default for every output not listed in a state is 0. Encodings 10-15 are unreachable and recover to FETCH on the next clock.
- opcode must be stable from DECODE until the instruction returns to FETCH; it is driven from the IR.
- Latency in clocks with mem_ready=1 on first assert:
  - R-type 4, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle on a memory state adds 1.
- Stall counter:
  - Increments each cycle a memory state (FETCH, MEM_READ, MEM_WRITE) waits with mem_ready=0.
  - Clears on mem_ready or on leaving the state.
- Timeout, when MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT:
  - mem_err sets.
  - FSM abandons the access and returns to FETCH; from FETCH it retries FETCH.
  - All strobes drop for that cycle.
- mem_ready while not in a memory state is ignored.
- Reset asserted mid-instruction: immediate return to FETCH. No partial reg_write or pc_write is issued after rst_n falls.

Optional Feature:
MIPS_ADDI_EN:
- Defined: opcode 0x08 (addi) is legal. DECODE -> ADDI_EX (10), which drives alu_src_a=1, alu_src_b=2, alu_op=0, then -> ADDI_WB (11), which drives reg_write=1, mem_to_reg=0, reg_dst=0, then -> FETCH.
- Undefined: 0x08 is illegal (illegal_op pulse) and states 10/11 are unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum/encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUSrcB, ALUOp and PCSource encodings.
- One sub-module is natural: mips_ctrl_outdec, a pure combinational state-to-control-word decoder. The FSM next-state logic and stall counter stay in the top module.

Test Plan:
- Reset: rst_n low mid-MEM_READ -> state_o=0, mem_err=0, reg_write=0 immediately; after release FETCH asserts mem_read=1, i_or_d=0.
- R-type with mem_ready always 1, opcode=0x00 -> states 0,1,6,7; in ALU_WB reg_dst=1, reg_write=1, mem_to_reg=0; back in FETCH on cycle 5.
- lw with opcode=0x23 and mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read=1, i_or_d=1; then MEM_WB with reg_dst=0, mem_to_reg=1.
- beq 0x04 -> BRANCH drives alu_op=1, pc_write_cond=1, pc_source=1; j 0x02 -> JUMP drives pc_write=1, pc_source=2; both take 3 cycles.
- opcode=0x3F in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, no reg_write or mem_write.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> mem_err rises after 4 wait cycles, FSM re-enters FETCH, mem_err stays 1 until reset.
